// File: rtl/lru_ctrl.sv
// lru_ctrl: sequencer and port arbiter for the 1-bit-per-set LRU table of the 2-way L1.
// Latency: victim_valid_o/victim_way_o one cycle after a lookup is accepted; table writes are same-cycle.
// Backpressure: req_ready_o drops while clearing or when an update claims the port. Optional macro LRU_FLUSH_EN adds flush_i.
module lru_ctrl #(
  parameter int INDEX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef LRU_FLUSH_EN
  input  logic               flush_i,
`endif
  output logic               init_done_o,
  input  logic               req_valid_i,
  input  logic [INDEX_W-1:0] req_index_i,
  output logic               req_ready_o,
  output logic               victim_valid_o,
  output logic               victim_way_o,
  input  logic               upd_valid_i,
  input  logic [INDEX_W-1:0] upd_index_i,
  input  logic               upd_way_i,
  output logic [INDEX_W-1:0] tbl_index_o,
  output logic               tbl_wr_en_o,
  output logic               tbl_wr_lru_o,
  input  logic               tbl_rd_lru_i
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INDEX_W-1:0] cnt;
  logic [INDEX_W-1:0] cnt_nxt;
  logic [INDEX_W-1:0] last_idx;
  logic               pending;
  logic               flush;

`ifdef LRU_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // State, sweep counter, held table index and the lookup-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      last_idx <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_idx <= tbl_index_o;
      pending  <= req_valid_i & req_ready_o;
    end
  end

  // Next state: sweep every index once, then serve traffic until a flush re-clears the table.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        // Counter wraps to 0 naturally after the last index.
        cnt_nxt = cnt + 1'b1;
        if (cnt == {INDEX_W{1'b1}}) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
    if (flush) begin
      state_nxt = INIT;
      cnt_nxt   = '0;
    end
  end

  // Outputs: sweep writes in INIT; in RUN updates win the port, otherwise an accepted lookup reads it.
  always_comb begin
    init_done_o    = (state == RUN);
    req_ready_o    = init_done_o & ~upd_valid_i & ~flush;
    tbl_index_o    = last_idx;
    tbl_wr_en_o    = 1'b0;
    tbl_wr_lru_o   = 1'b0;
    if (state == INIT) begin
      tbl_index_o  = cnt;
      tbl_wr_en_o  = 1'b1;
    end else if (upd_valid_i) begin
      // Stored bit names the way that was not just used.
      tbl_index_o  = upd_index_i;
      tbl_wr_en_o  = 1'b1;
      tbl_wr_lru_o = ~upd_way_i;
    end else if (req_valid_i & req_ready_o) begin
      tbl_index_o  = req_index_i;
    end
    // The table read data lines up with the cycle after acceptance.
    victim_valid_o = pending;
    victim_way_o   = pending & tbl_rd_lru_i;
  end

endmodule

// File: tb/tb_lru_ctrl.sv
// Bench for lru_ctrl: directed cases plus randomized traffic checked against a set-level LRU model.
// Includes a model of the single-port table with registered read so the victim path is exercised end to end.
// Every comparison goes through check_eq; one summary line at the end.
module tb_lru_ctrl;
  localparam int IW    = 8;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          req_valid;
  logic [IW-1:0] req_index;
  logic          req_ready;
  logic          victim_valid;
  logic          victim_way;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic          upd_way;
  logic [IW-1:0] tbl_index;
  logic          tbl_wr_en;
  logic          tbl_wr_lru;
  logic          tbl_rd_lru = 1'b0;
`ifdef LRU_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  lru_ctrl #(.INDEX_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef LRU_FLUSH_EN
    .flush_i        (flush),
`endif
    .init_done_o    (init_done),
    .req_valid_i    (req_valid),
    .req_index_i    (req_index),
    .req_ready_o    (req_ready),
    .victim_valid_o (victim_valid),
    .victim_way_o   (victim_way),
    .upd_valid_i    (upd_valid),
    .upd_index_i    (upd_index),
    .upd_way_i      (upd_way),
    .tbl_index_o    (tbl_index),
    .tbl_wr_en_o    (tbl_wr_en),
    .tbl_wr_lru_o   (tbl_wr_lru),
    .tbl_rd_lru_i   (tbl_rd_lru)
  );

  // Table model: no reset, one port, read data registered (old value on same-cycle write).
  bit tbl_mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_wr_en) tbl_mem[tbl_index] <= tbl_wr_lru;
    tbl_rd_lru <= tbl_mem[tbl_index];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the LRU way of every set, plus the victim expected next cycle.
  bit ref_lru [DEPTH];
  bit exp_vv = 1'b0;
  bit exp_vw = 1'b0;
  bit obs_vv;
  bit obs_vw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One RUN cycle: drive, check at negedge against the model, advance the model, move past posedge.
  task automatic step(input bit uv, input int ui, input bit uw, input bit rv, input int ri, output bit acc);
    upd_valid = uv;
    upd_index = ui[IW-1:0];
    upd_way   = uw;
    req_valid = rv;
    req_index = ri[IW-1:0];
    @(negedge clk);
    check_eq("run_init_done", init_done, 1);
    check_eq("run_req_ready", req_ready, !uv);
    check_eq("run_wr_en", tbl_wr_en, uv);
    if (uv) begin
      check_eq("upd_index", tbl_index, ui);
      check_eq("upd_data", tbl_wr_lru, !uw);
    end else if (rv) begin
      check_eq("req_index", tbl_index, ri);
    end
    check_eq("victim_valid", victim_valid, exp_vv);
    check_eq("victim_way", victim_way, exp_vv ? exp_vw : 1'b0);
    obs_vv = victim_valid;
    obs_vw = victim_way;
    acc    = rv && !uv;
    exp_vv = acc;
    if (acc) exp_vw = ref_lru[ri];
    if (uv) ref_lru[ui] = !uw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit a;
    step(0, 0, 0, 0, 0, a);
  endtask

  // Clear sweep of n cycles with random traffic that must be ignored.
  task automatic sweep(input int n, input bit full);
    int nz;
    for (int i = 0; i < n; i++) begin
      upd_valid = $urandom_range(0, 1);
      upd_index = IW'($urandom);
      upd_way   = $urandom_range(0, 1);
      req_valid = $urandom_range(0, 1);
      req_index = IW'($urandom);
      @(negedge clk);
      check_eq("sweep_wr_en", tbl_wr_en, 1);
      check_eq("sweep_index", tbl_index, i);
      check_eq("sweep_data", tbl_wr_lru, 0);
      check_eq("sweep_ready", req_ready, 0);
      check_eq("sweep_done", init_done, 0);
      check_eq("sweep_victim", victim_valid, 0);
      @(posedge clk);
      #1;
    end
    if (full) begin
      upd_valid = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("done_after_sweep", init_done, 1);
      check_eq("idle_wr_en", tbl_wr_en, 0);
      @(posedge clk);
      #1;
      nz = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (tbl_mem[i]) nz++;
        ref_lru[i] = 1'b0;
      end
      check_eq("table_cleared", nz, 0);
      exp_vv = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    bit hold;
    bit uv, uw, rv;
    int ui, ri;

    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = 1'($urandom);
    rst = 1'b1; upd_valid = 1'b0; upd_index = '0; upd_way = 1'b0;
    req_valid = 1'b0; req_index = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sweep(DEPTH, 1);

    // Fresh lookup returns way 0.
    step(0, 0, 0, 1, 'h12, acc);
    idle();
    check_eq("t2_vv", obs_vv, 1);
    check_eq("t2_vw", obs_vw, 0);

    // Update then lookup the same set on the next cycle.
    step(1, 'h12, 0, 0, 0, acc);
    step(0, 0, 0, 1, 'h12, acc);
    idle();
    check_eq("t3_way1", obs_vw, 1);
    step(1, 'h12, 1, 0, 0, acc);
    step(0, 0, 0, 1, 'h12, acc);
    idle();
    check_eq("t3_way0", obs_vw, 0);

    // Update and lookup together: update wins, lookup held and accepted next.
    step(1, 'h05, 1, 1, 'h06, acc);
    step(0, 0, 0, 1, 'h06, acc);
    idle();
    check_eq("t4_vv", obs_vv, 1);
    check_eq("t4_vw", obs_vw, 0);

    // Back-to-back lookups of sets preloaded to 1,0,1.
    step(1, 'h01, 0, 0, 0, acc);
    step(1, 'h02, 1, 0, 0, acc);
    step(1, 'h03, 0, 0, 0, acc);
    step(0, 0, 0, 1, 'h01, acc);
    step(0, 0, 0, 1, 'h02, acc);
    check_eq("t5_a", obs_vw, 1);
    step(0, 0, 0, 1, 'h03, acc);
    check_eq("t5_b", obs_vw, 0);
    idle();
    check_eq("t5_c", obs_vw, 1);

    // Lookup then update of the same set: victim shows the pre-update value.
    step(0, 0, 0, 1, 'h20, acc);
    step(1, 'h20, 0, 0, 0, acc);
    check_eq("haz_pre", obs_vw, 0);
    step(0, 0, 0, 1, 'h20, acc);
    idle();
    check_eq("haz_post", obs_vw, 1);

    // Randomized traffic over a few sets; a stalled lookup is held stable.
    hold = 1'b0; rv = 1'b0; ri = 0;
    for (int k = 0; k < 3000; k++) begin
      uv = ($urandom_range(0, 2) == 0);
      ui = $urandom_range(0, 7);
      uw = $urandom_range(0, 1);
      if (!hold) begin
        rv = $urandom_range(0, 1);
        ri = $urandom_range(0, 7);
      end
      step(uv, ui, uw, rv, ri, acc);
      hold = rv && !acc;
    end
    idle();

    // Set 0x40 to 1, confirm, then reset with a lookup in flight and again mid-sweep.
    step(1, 'h40, 0, 0, 0, acc);
    step(0, 0, 0, 1, 'h40, acc);
    idle();
    check_eq("pre_rst_40", obs_vw, 1);
    rst = 1'b1; req_valid = 1'b1; req_index = 'h40;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(100, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_sweep_index", tbl_index, 100);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(DEPTH, 1);
    step(0, 0, 0, 1, 'h40, acc);
    idle();
    check_eq("post_rst_vv", obs_vv, 1);
    check_eq("post_rst_40", obs_vw, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lru_ctrl.md
Name: lru_ctrl

Overview:
- Sequencer and port arbiter for the single-port 1-bit-per-set LRU table of the 2-way L1 cache.
- Clears every table entry after reset, since the table itself has no reset.
- Arbitrates the table's one index port between the cache lookup path (victim read) and the hit/refill path (LRU update).
- Sits between the cache control FSM and the LRU table instance.

Parameters:
- INDEX_W, 8, set-index width; table depth = 2**INDEX_W (256 sets).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done_o  out  1  high once the table clear sweep has finished
- req_valid_i  in  1  lookup request (victim read)
- req_index_i  in  INDEX_W  lookup set index
- req_ready_o  out  1  lookup accepted this cycle when high with req_valid_i
- victim_valid_o  out  1  single-cycle pulse; victim_way_o is valid
- victim_way_o  out  1  way to replace (0/1)
- upd_valid_i  in  1  LRU update request
- upd_index_i  in  INDEX_W  update set index
- upd_way_i  in  1  way just used (hit or refilled)
- tbl_index_o  out  INDEX_W  to table index_i
- tbl_wr_en_o  out  1  to table wr_en_i
- tbl_wr_lru_o  out  1  to table wr_lru_i
- tbl_rd_lru_i  in  1  from table rd_lru_o (registered, 1-cycle read latency)

Behaviour:
- Reset (synchronous, any cycle, including mid-sweep or with a lookup in flight):
  - state←INIT, sweep counter←0.
  - init_done_o=0, victim_valid_o=0, victim_way_o=0.
  - req_ready_o=0 while in INIT.
- State INIT:
  - tbl_index_o=counter, tbl_wr_en_o=1, tbl_wr_lru_o=0; counter increments every cycle.
  - After the write to index 2**INDEX_W-1, next state is RUN and counter wraps to 0.
  - Sweep lasts exactly 2**INDEX_W cycles; init_done_o rises the cycle after the last write.
  - upd_valid_i and req_valid_i are ignored in INIT: no writes, no victims, req_ready_o=0.
- State RUN (init_done_o=1):
  - Update has priority. When upd_valid_i=1:
    - tbl_index_o=upd_index_i, tbl_wr_en_o=1, tbl_wr_lru_o=~upd_way_i.
    - Stored bit names the least-recently-used way.
    - req_ready_o=0 in that cycle.
  - Else when req_valid_i=1:
    - req_ready_o=1, tbl_index_o=req_index_i, tbl_wr_en_o=0.
    - A registered pending flag is set.
  - Else tbl_wr_en_o=0 and tbl_index_o holds its last driven value; reads are harmless.
  - req_ready_o is combinational: init_done_o & ~upd_valid_i.
  - Victim latency: one cycle after acceptance, victim_valid_o=1 and victim_way_o=tbl_rd_lru_i; otherwise victim_valid_o=0.
  - Back-to-back lookups: one per cycle, one victim pulse per accepted request, in order.
  - Same-set hazard:
    - Update to set S in cycle t, lookup to S accepted in t+1 → victim reflects the update (table written at the end of t).
    - Lookup accepted at t and update to S at t+1 → victim at t+1 shows the pre-update value.
  - A stalled requester holds req_valid_i/req_index_i stable until req_ready_o=1.
- tbl_* outputs are combinational from state, counter and inputs; all state is clocked on posedge clk.

Optional Feature:
- Macro: LRU_FLUSH_EN.
- Defined:
  - Extra port flush_i (in, 1). A flush_i pulse in RUN moves the block to INIT next cycle: counter←0, init_done_o←0, full 2**INDEX_W-cycle re-clear.
  - In the flush cycle, a same-cycle update is still written and a same-cycle lookup is not accepted (req_ready_o=0).
  - An already-accepted lookup still produces its victim pulse.
  - flush_i during INIT restarts the counter at 0.
- Undefined: no flush_i port; INIT is entered only by rst.

Test Plan:
- Reset, INDEX_W=8 → tbl_wr_en_o=1 for exactly 256 cycles, indices 0..255 with data 0; init_done_o=1 on cycle 257; req_ready_o=0 throughout the sweep.
- After init, lookup set 0x12 → victim_valid_o pulse one cycle later with victim_way_o=0; no table write.
- Update set 0x12 way 0, then lookup 0x12 the next cycle → tbl_wr_lru_o=1 during the update, victim_way_o=1; then update way 1 and lookup → victim_way_o=0.
- upd_valid_i and req_valid_i together (sets 0x05/0x06) → req_ready_o=0, write to 0x05; lookup accepted next cycle, victim pulse the cycle after.
- Lookups to 0x01,0x02,0x03 on consecutive cycles with table pre-set to 1,0,1 → victim pulses 1,0,1 on three consecutive cycles.
- rst asserted at sweep index 100 (or LRU_FLUSH_EN: flush_i in RUN after writing set 0x40 to 1) → sweep restarts at 0, init_done_o=0, and a lookup of 0x40 afterwards returns 0.
